// File: rtl/ul4_reg_pkg.sv
// Shared opcode definitions for the registered logic unit and its 1-bit cells.
package ul4_reg_pkg;

   typedef logic [1:0] op_t;

   localparam op_t OP_OR   = 2'b00;
   localparam op_t OP_AND  = 2'b01;
   localparam op_t OP_XOR  = 2'b10;
   localparam op_t OP_NOTA = 2'b11;

endpackage

// File: rtl/ul4_reg_ul_cell.sv
// Purely combinational 1-bit logic cell; the opcode selects OR/AND/XOR/NOT-A.
module ul_cell
   import ul4_reg_pkg::*;
(
   input  logic a,
   input  logic b,
   input  op_t  s,
   output logic y
);

   always_comb begin
      y = 1'b0;
      unique case (s)
         OP_OR:   y = a | b;
         OP_AND:  y = a & b;
         OP_XOR:  y = a ^ b;
         OP_NOTA: y = ~a;
         default: y = 1'b0;
      endcase
   end

endmodule

// File: rtl/ul4_reg.sv
// W-bit logic slice built from ul_cell copies, with a registered result,
// valid flag and zero flag.
module ul4_reg
   import ul4_reg_pkg::*;
#(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  op_t          s,
   output logic [W-1:0] out,
   output logic         out_valid,
   output logic         zero
);

   // Handshake: in_valid qualifies a/b/s at a rising edge; there is no ready,
   // every valid input is accepted and its result shows one cycle later with
   // out_valid=1. out/zero hold on idle cycles, out_valid does not.

   logic [W-1:0] res;
   logic [W-1:0] out_d, out_q;
   logic         out_valid_d, out_valid_q;
   logic         zero_d, zero_q;

   for (genvar i = 0; i < W; i++) begin : g_cell
      ul_cell u_cell (
         .a (a[i]),
         .b (b[i]),
         .s (s),
         .y (res[i])
      );
   end

   always_comb begin
      out_d       = out_q;
      zero_d      = zero_q;
      out_valid_d = in_valid;
      if (in_valid) begin
         out_d  = res;
         zero_d = (res == '0);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_q       <= '0;
         out_valid_q <= 1'b0;
         zero_q      <= 1'b0;
      end else begin
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
         zero_q      <= zero_d;
      end
   end

   assign out       = out_q;
   assign out_valid = out_valid_q;
   assign zero      = zero_q;

endmodule

// File: tb/tb_ul4_reg.sv
// Directed and exhaustive checks of ul4_reg at W=4.
module tb_ul4_reg;

   localparam int W = 4;

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic [1:0]   s;
   logic [W-1:0] out;
   logic         out_valid;
   logic         zero;

   int n_checks = 0;
   int n_errors = 0;

   ul4_reg #(.W(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .a         (a),
      .b         (b),
      .s         (s),
      .out       (out),
      .out_valid (out_valid),
      .zero      (zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%b expected=%b", tag, got, exp);
      end
   endtask

   // Drive one input set, advance one edge, then sample 1 time unit later.
   task automatic step(input logic rst, input logic v, input logic [1:0] op,
                       input logic [W-1:0] av, input logic [W-1:0] bv);
      rst_n    = rst;
      in_valid = v;
      s        = op;
      a        = av;
      b        = bv;
      @(posedge clk);
      #1;
   endtask

   task automatic expect_out(input string tag, input logic [W-1:0] eo,
                             input logic ev, input logic ez);
      check({tag, ".out"}, out, eo);
      check({tag, ".out_valid"}, {3'b000, out_valid}, {3'b000, ev});
      check({tag, ".zero"}, {3'b000, zero}, {3'b000, ez});
   endtask

   function automatic logic [W-1:0] ref_model(input logic [1:0] op,
                                              input logic [W-1:0] av,
                                              input logic [W-1:0] bv);
      case (op)
         2'b00:   return av | bv;
         2'b01:   return av & bv;
         2'b10:   return av ^ bv;
         default: return ~av;
      endcase
   endfunction

   initial begin
      logic [W-1:0] e;
      rst_n = 1'b0; in_valid = 1'b0; s = 2'b00; a = '0; b = '0;

      @(negedge clk);
      step(1'b0, 1'b0, 2'b00, 4'b0000, 4'b0000);
      step(1'b0, 1'b0, 2'b00, 4'b0000, 4'b0000);
      expect_out("reset", 4'b0000, 1'b0, 1'b0);

      step(1'b1, 1'b1, 2'b01, 4'b0110, 4'b0100);
      expect_out("and", 4'b0100, 1'b1, 1'b0);
      step(1'b1, 1'b1, 2'b10, 4'b1001, 4'b0100);
      expect_out("xor", 4'b1101, 1'b1, 1'b0);
      step(1'b1, 1'b1, 2'b00, 4'b1111, 4'b0100);
      expect_out("or", 4'b1111, 1'b1, 1'b0);
      step(1'b1, 1'b1, 2'b11, 4'b1111, 4'b0100);
      expect_out("nota_zero", 4'b0000, 1'b1, 1'b1);
      step(1'b1, 1'b1, 2'b10, 4'b1111, 4'b1111);
      expect_out("xor_zero", 4'b0000, 1'b1, 1'b1);
      step(1'b1, 1'b1, 2'b11, 4'b0101, 4'b1111);
      expect_out("nota_ignores_b", 4'b1010, 1'b1, 1'b0);

      step(1'b1, 1'b1, 2'b01, 4'b0110, 4'b0100);
      expect_out("and2", 4'b0100, 1'b1, 1'b0);
      step(1'b1, 1'b0, 2'b00, 4'b1111, 4'b0000);
      expect_out("hold1", 4'b0100, 1'b0, 1'b0);
      step(1'b1, 1'b0, 2'b11, 4'b0000, 4'b0000);
      expect_out("hold2", 4'b0100, 1'b0, 1'b0);

      step(1'b0, 1'b1, 2'b00, 4'b1010, 4'b0101);
      expect_out("mid_reset", 4'b0000, 1'b0, 1'b0);
      step(1'b1, 1'b1, 2'b00, 4'b1010, 4'b0101);
      expect_out("after_reset", 4'b1111, 1'b1, 1'b0);

      // Back-to-back sweep: a stale or late result shows up as a wrong out.
      for (int op = 0; op < 4; op++) begin
         for (int ab = 0; ab < 256; ab++) begin
            logic [W-1:0] av, bv;
            av = ab[7:4];
            bv = ab[3:0];
            e  = ref_model(op[1:0], av, bv);
            step(1'b1, 1'b1, op[1:0], av, bv);
            expect_out($sformatf("sweep_s%0d_a%h_b%h", op, av, bv), e, 1'b1, e == '0);
         end
      end

      step(1'b1, 1'b0, 2'b00, 4'b0000, 4'b0000);
      expect_out("idle_end", 4'b0000, 1'b0, 1'b1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/ul4_reg.md
Name: ul4_reg

Overview:
- Registered 4-bit logic unit (default width), one op per cycle, selected by a 2-bit opcode.
- Built from identical 1-bit logic cells; the result is captured in an output register with a valid flag.
- Used as the logic (non-arithmetic) slice of a simple datapath/ALU; no carry, no arithmetic.

Parameters:
- W, 4, operand and result width in bits (W >= 1).

Ports:
- clk  input  1  rising-edge clock, sole clock domain.
- rst_n  input  1  synchronous, active-low reset, sampled on rising clk.
- in_valid  input  1  operands/opcode valid this cycle.
- a  input  W  operand A.
- b  input  W  operand B.
- s  input  2  opcode select.
- out  output  W  registered result.
- out_valid  output  1  out holds a result computed from the previous cycle's accepted inputs.
- zero  output  1  registered flag, 1 when the captured result is all zeros.

Behaviour:
- Opcode map, bitwise per bit i:
  - s=00: out[i] = a[i] OR b[i].
  - s=01: out[i] = a[i] AND b[i].
  - s=10: out[i] = a[i] XOR b[i].
  - s=11: out[i] = NOT a[i]; b is ignored.
- Reset: on a rising clk with rst_n=0, out <= 0, out_valid <= 0, zero <= 0. Reset has priority over in_valid.
- Latency: exactly 1 cycle. Inputs sampled at edge k with in_valid=1 appear on out/zero after edge k, and out_valid=1 for that cycle.
- in_valid=0 at an edge:
  - out and zero hold their previous values.
  - out_valid <= 0.
- Back-to-back valid inputs give one result per cycle. There is no backpressure and no ready signal.
- zero <= (computed result == 0), updated only when a result is captured.
- Reset asserted mid-stream discards the in-flight result; the first result after rst_n returns high comes from the first valid input sampled with rst_n=1.
- All outputs come directly from flops; there is no combinational path from inputs to outputs.
- X/unknown opcode cannot occur: s is exactly 2 bits and all 4 codes are defined.
- Width rule: all operations are bitwise, so there is no overflow and out is exactly W bits.

Decomposition:
- Shared package holds:
  - opcode constants OP_OR=2'b00, OP_AND=2'b01, OP_XOR=2'b10, OP_NOTA=2'b11;
  - a typedef for the 2-bit opcode.
- One natural sub-module: ul_cell, a purely combinational 1-bit cell (inputs a, b, s; output y) implementing the opcode map.
- ul4_reg instantiates W copies of ul_cell via generate, then adds the output register, the valid flop and the zero-detect.

Test Plan:
- Reset then AND: hold rst_n=0 for 2 cycles (out=0000, out_valid=0, zero=0); then s=01, a=0110, b=0100, in_valid=1 -> next cycle out=0100, out_valid=1, zero=0.
- XOR and OR: s=10, a=1001, b=0100 -> out=1101; then s=00, a=1111, b=0100 -> out=1111. Both on consecutive cycles with out_valid=1 each cycle.
- NOT A with zero flag: s=11, a=1111, b=0100 -> out=0000, zero=1. Then s=10, a=1111, b=1111 -> out=0000, zero=1 (b ignored only for s=11).
- Hold behaviour: after s=01, a=0110, b=0100 (out=0100), drive in_valid=0 with s=00, a=1111 -> out stays 0100, zero stays 0, out_valid=0.
- Reset mid-operation: present s=00, a=1010, b=0101 with in_valid=1 and rst_n=0 at the same edge -> out=0000, out_valid=0, zero=0. The next valid input with rst_n=1 produces a normal result one cycle later.
- Exhaustive sweep: all 4 opcodes x all 256 (a,b) pairs at W=4 against a reference model; check out, zero, and 1-cycle latency for each.
